// File: rtl/core_hamming_encoder.sv
// Hamming(7,4) flit encoder: {IP, data} words in, {IP, codeword} flits out through a small FIFO,
// with a one-shot single-bit error injector and a wrapping count of flits handed to the router.
module core_hamming_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [10:0]      out_data,
    input  logic             out_ready,
    input  logic             inj_req,
    input  logic [2:0]       inj_pos,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic {
        INJ_IDLE,
        INJ_ARMED
    } inj_state_t;

    logic [10:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic             ready_q;
    inj_state_t       inj_state;
    logic [2:0]       inj_pos_q;

    logic             full;
    logic             push;
    logic             pop;
    logic [6:0]       flip_mask;
    logic [6:0]       codeword;
    logic [10:0]      flit;

    // Codeword bit i carries Hamming position i+1; parities sit at positions 1, 2 and 4.
    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic [6:0] cw;
        cw[2] = d[0];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[3] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

    // ready_q keeps in_ready low while reset is held, independent of the emptied FIFO.
    always_comb begin
        full      = (occupancy == OCC_FULL);
        in_ready  = ready_q & ~full;
        out_valid = (occupancy != '0);
        out_data  = fifo_mem[rd_ptr];
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        flip_mask = '0;
        for (int i = 0; i < 7; i++) begin
            flip_mask[i] = (inj_state == INJ_ARMED) && (inj_pos_q == 3'(i + 1));
        end
        codeword  = hamming_encode(in_data[3:0]) ^ flip_mask;
        flit      = {in_data[7:4], codeword};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            ready_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            if (push) begin
                fifo_mem[wr_ptr] <= flit;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // A new request always wins: a transfer in the same cycle consumes the old arming only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inj_state <= INJ_IDLE;
            inj_pos_q <= '0;
        end else if (inj_req) begin
            inj_pos_q <= inj_pos;
            inj_state <= (inj_pos != 3'd0) ? INJ_ARMED : INJ_IDLE;
        end else if (push && inj_state == INJ_ARMED) begin
            inj_state <= INJ_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sent_cnt <= '0;
        end else if (pop) begin
            sent_cnt <= sent_cnt + CNT_W'(1);
        end
    end

endmodule
